// File: rtl/div_pkg.sv
// Shared types for the sequential divider: FSM state encoding.
package div_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bus between controller and divider.
interface div_if #(parameter int W = 8);
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;

  modport master (output start, sgn, a, b, input busy, done, q, r, dbz);
  modport slave  (input start, sgn, a, b, output busy, done, q, r, dbz);
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: W+1-bit trial subtract of the shifted remainder.
module div_step #(parameter int W = 8) (
  input  logic [W-1:0] rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);
  logic [W:0] shifted;
  logic [W:0] trial;

  assign shifted = {rem, dvd_msb};
  assign trial   = shifted - {1'b0, divisor};
  // A clear sign bit means the divisor fits; otherwise restore the shifted remainder.
  assign q_bit   = ~trial[W];
  assign rem_nxt = q_bit ? trial[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: W cycles per division, optional signed mode,
// divide-by-zero short-circuits straight to the result cycle.
module div_seq
  import div_pkg::*;
#(parameter int W = 8) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem, dvd, dvs;
  logic          neg_q, neg_r;
  logic [W-1:0]  q_reg, r_reg;
  logic          dbz_reg;

  logic          accept;
  logic          last_iter;
  logic [W-1:0]  rem_nxt;
  logic          q_bit;
  logic [W-1:0]  q_fin;
  logic [W-1:0]  mag_a, mag_b;

  div_step #(.W(W)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[W-1]),
    .divisor (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign accept    = bus.start && (state != CALC);
  assign last_iter = (state == CALC) && (cnt == CW'(1));
  assign q_fin     = {dvd[W-2:0], q_bit};
  assign mag_a     = (bus.sgn && bus.a[W-1]) ? (~bus.a + 1'b1) : bus.a;
  assign mag_b     = (bus.sgn && bus.b[W-1]) ? (~bus.b + 1'b1) : bus.b;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_nxt = (bus.b == '0) ? DONE : CALC;
        else           state_nxt = IDLE;
      end
      CALC:    if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else if (accept) begin
      if (bus.b == '0) begin
        q_reg   <= '1;
        r_reg   <= bus.a;
        dbz_reg <= 1'b1;
      end else begin
        dvd   <= mag_a;
        dvs   <= mag_b;
        rem   <= '0;
        cnt   <= CW'(W);
        neg_q <= bus.sgn && (bus.a[W-1] ^ bus.b[W-1]);
        neg_r <= bus.sgn && bus.a[W-1];
      end
    end else if (state == CALC) begin
      rem <= rem_nxt;
      dvd <= q_fin;
      cnt <= cnt - 1'b1;
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      if (last_iter) begin
        q_reg   <= neg_q ? (~q_fin + 1'b1) : q_fin;
        r_reg   <= neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
        dbz_reg <= 1'b0;
      end
    end
  end

  assign bus.busy = (state == CALC);
  assign bus.done = (state == DONE);
  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.dbz  = dbz_reg;
endmodule
